// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared address type, next-PC op encoding and instruction size for pc_gen.
package pc_gen_pkg;
  localparam int ADDR_W = 32;
  localparam int INST_BYTES = 4;
  typedef logic [ADDR_W-1:0] inst_addr_t;
  typedef enum logic [2:0] {
    PC_SEQ  = 3'd0,
    PC_REL  = 3'd1,
    PC_REG  = 3'd2,
    PC_TRAP = 3'd3,
    PC_RET  = 3'd4
  } pc_op_t;
endpackage

// File: rtl/ras_stack.sv
// ras_stack: circular return address stack; pushing when full overwrites the oldest entry,
// push+pop together replaces the top in place.
module ras_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] ptr;
  logic [CW-1:0] count;
  assign top = mem[ptr];
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  always_ff @(posedge clk)
    if (push) mem[pop ? ptr : ptr + PW'(1)] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ptr <= '0;
      count <= '0;
    end else if (push && !pop) begin
      ptr <= ptr + PW'(1);
      count <= full ? count : count + CW'(1);
    end else if (pop && !push && !empty) begin
      ptr <= ptr - PW'(1);
      count <= count - CW'(1);
    end
endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch-stage PC register with SEQ/REL/REG/TRAP/RET next-PC selection and a RAS.
// Define PCGEN_COMPRESSED_EN to add i_instSize (2-byte instructions, bit0 alignment check).
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int RAS_DEPTH = 4
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_stall,
  input  logic [2:0]            i_op,
  input  inst_addr_t            i_instIMM,
  input  inst_addr_t            i_regData,
  input  logic [ADDR_WIDTH-1:0] i_trapVector,
  input  logic                  i_rasPush,
  input  logic                  i_rasPop,
`ifdef PCGEN_COMPRESSED_EN
  input  logic                  i_instSize,
`endif
  output logic [ADDR_WIDTH-1:0] o_pc,
  output logic                  o_misaligned,
  output logic                  o_rasEmpty,
  output logic                  o_rasFull
);
  typedef logic [ADDR_WIDTH-1:0] addr_t;
`ifdef PCGEN_COMPRESSED_EN
  localparam int CHK_BIT = 0;
  addr_t inc;
  assign inc = i_instSize ? addr_t'(2) : addr_t'(INST_BYTES);
`else
  localparam int CHK_BIT = 1;
  addr_t inc;
  assign inc = addr_t'(INST_BYTES);
`endif
  pc_op_t op;
  addr_t imm, link, rel_t, reg_t, target, ras_top;
  logic mis, ok, ras_empty;
  assign op = pc_op_t'(i_op);
  assign imm = addr_t'($signed(i_instIMM));
  assign link = o_pc + inc;
  assign rel_t = o_pc + imm;
  assign reg_t = (addr_t'(i_regData) + imm) & ~addr_t'(1);
  always_comb begin
    target = op == PC_REL  ? rel_t :
             op == PC_REG  ? reg_t :
             op == PC_TRAP ? i_trapVector :
             op == PC_RET  ? (ras_empty ? reg_t : ras_top) : link;
    mis = op != PC_TRAP && target[CHK_BIT];
    ok = !i_stall && !mis;
  end
  ras_stack #(.DEPTH(RAS_DEPTH), .WIDTH(ADDR_WIDTH)) u_ras (
    .clk(i_clock),
    .rst_n(i_reset),
    .push(i_rasPush && ok),
    .pop(i_rasPop && ok),
    .din(link),
    .top(ras_top),
    .empty(ras_empty),
    .full(o_rasFull)
  );
  assign o_rasEmpty = ras_empty;
  always_ff @(posedge i_clock or negedge i_reset)
    if (!i_reset) begin
      o_pc <= RESET_VECTOR;
      o_misaligned <= 1'b0;
    end else begin
      o_misaligned <= !i_stall && mis;
      if (ok) o_pc <= target;
    end
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed-vector self-checking bench for pc_gen (honours PCGEN_COMPRESSED_EN).
module tb_pc_gen;
  logic clk = 1'b0, rst_n = 1'b0, stall = 1'b0, push = 1'b0, pop = 1'b0;
  logic [2:0] op = '0;
  logic [31:0] imm = '0, regd = '0, tvec = '0, pc;
  logic mis, empty, full;
  int cmp = 0, bad = 0;
`ifdef PCGEN_COMPRESSED_EN
  logic isz = 1'b0;
`endif
  pc_gen dut (
    .i_clock(clk), .i_reset(rst_n), .i_stall(stall), .i_op(op), .i_instIMM(imm),
    .i_regData(regd), .i_trapVector(tvec), .i_rasPush(push), .i_rasPop(pop),
`ifdef PCGEN_COMPRESSED_EN
    .i_instSize(isz),
`endif
    .o_pc(pc), .o_misaligned(mis), .o_rasEmpty(empty), .o_rasFull(full)
  );
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] o, input logic [31:0] im, input logic [31:0] rg,
                       input logic ps, input logic pp);
    op = o; imm = im; regd = rg; push = ps; pop = pp;
  endtask

  task automatic test_reset;
    tick();
    cmp++; if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc got %h want %h", pc, 32'h0); end
    cmp++; if (empty !== 1'b1 || full !== 1'b0 || mis !== 1'b0) begin bad++; $display("FAIL reset_flags got e%b f%b m%b want e1 f0 m0", empty, full, mis); end
    rst_n = 1'b1;
    drive(3'd2, 32'h0, 32'h300, 1'b1, 1'b0);
    tick();
    cmp++; if (pc !== 32'h300 || empty !== 1'b0) begin bad++; $display("FAIL pre_reset got pc %h e%b want 300 e0", pc, empty); end
    drive(3'd1, 32'h40, 32'h0, 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    cmp++; if (pc !== 32'h0 || empty !== 1'b1) begin bad++; $display("FAIL async_reset got pc %h e%b want 0 e1", pc, empty); end
    tick();
    rst_n = 1'b1;
    drive(3'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      cmp++; if (pc !== 32'(4 * i) || empty !== 1'b1) begin bad++; $display("FAIL seq_%0d got pc %h e%b want %h e1", i, pc, empty, 32'(4 * i)); end
    end
  endtask

  task automatic test_rel_reg;
    drive(3'd2, 32'h0, 32'h100, 1'b0, 1'b0);
    tick();
    cmp++; if (pc !== 32'h100) begin bad++; $display("FAIL reg_100 got %h want 100", pc); end
    drive(3'd1, 32'hFFFF_FFF8, 32'h0, 1'b0, 1'b0);
    tick();
    cmp++; if (pc !== 32'h0F8) begin bad++; $display("FAIL rel_neg got %h want 0f8", pc); end
    drive(3'd2, 32'h0, 32'h2001, 1'b0, 1'b0);
    tick();
    cmp++; if (pc !== 32'h2000) begin bad++; $display("FAIL reg_bit0 got %h want 2000", pc); end
    drive(3'd2, 32'h21, 32'h1000, 1'b0, 1'b0);
    tick();
    cmp++; if (pc !== 32'h1020) begin bad++; $display("FAIL reg_imm got %h want 1020", pc); end
    drive(3'd5, 32'h80, 32'h0, 1'b0, 1'b0);
    tick();
    cmp++; if (pc !== 32'h1024) begin bad++; $display("FAIL op5_seq got %h want 1024", pc); end
  endtask

  task automatic test_misaligned;
    drive(3'd2, 32'h0, 32'h40, 1'b0, 1'b0);
    tick();
    drive(3'd1, 32'h2, 32'h0, 1'b1, 1'b0);
    tick();
`ifdef PCGEN_COMPRESSED_EN
    cmp++; if (pc !== 32'h42 || mis !== 1'b0 || empty !== 1'b0) begin bad++; $display("FAIL rel2 got pc %h m%b e%b want 42 m0 e0", pc, mis, empty); end
`else
    cmp++; if (pc !== 32'h40 || mis !== 1'b1 || empty !== 1'b1) begin bad++; $display("FAIL rel2 got pc %h m%b e%b want 40 m1 e1", pc, mis, empty); end
`endif
    drive(3'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
`ifdef PCGEN_COMPRESSED_EN
    cmp++; if (pc !== 32'h46 || mis !== 1'b0) begin bad++; $display("FAIL mis_after got pc %h m%b want 46 m0", pc, mis); end
`else
    cmp++; if (pc !== 32'h44 || mis !== 1'b0) begin bad++; $display("FAIL mis_after got pc %h m%b want 44 m0", pc, mis); end
`endif
    tvec = 32'h1002;
    drive(3'd3, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    cmp++; if (pc !== 32'h1002 || mis !== 1'b0) begin bad++; $display("FAIL trap_unchecked got pc %h m%b want 1002 m0", pc, mis); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_ras;
    drive(3'd2, 32'h0, 32'h10, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(3'd2, 32'h0, 32'(32'h20 + 16 * i), 1'b1, 1'b0);
      tick();
      cmp++; if (pc !== 32'(32'h20 + 16 * i) || full !== (i >= 3)) begin bad++; $display("FAIL push_%0d got pc %h f%b want %h f%b", i, pc, full, 32'(32'h20 + 16 * i), i >= 3); end
    end
    cmp++; if (empty !== 1'b0) begin bad++; $display("FAIL ras_nonempty got e%b want e0", empty); end
    for (int i = 0; i < 4; i++) begin
      drive(3'd4, 32'h0, 32'h0, 1'b0, 1'b1);
      tick();
      cmp++; if (pc !== 32'(32'h54 - 16 * i)) begin bad++; $display("FAIL ret_%0d got %h want %h", i, pc, 32'(32'h54 - 16 * i)); end
    end
    cmp++; if (empty !== 1'b1 || full !== 1'b0) begin bad++; $display("FAIL ras_drained got e%b f%b want e1 f0", empty, full); end
    drive(3'd4, 32'h0, 32'h800, 1'b0, 1'b1);
    tick();
    cmp++; if (pc !== 32'h800 || empty !== 1'b1) begin bad++; $display("FAIL ret_empty got pc %h e%b want 800 e1", pc, empty); end
  endtask

  task automatic test_stall;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(3'd1, i == 2 ? 32'h2 : 32'h8, 32'h0, 1'b1, 1'b0);
      tick();
      cmp++; if (pc !== 32'h800 || empty !== 1'b1 || mis !== 1'b0) begin bad++; $display("FAIL stall_%0d got pc %h e%b m%b want 800 e1 m0", i, pc, empty, mis); end
    end
    stall = 1'b0;
    drive(3'd2, 32'h0, 32'h80, 1'b1, 1'b0);
    tick();
    cmp++; if (pc !== 32'h80 || empty !== 1'b0) begin bad++; $display("FAIL push_804 got pc %h e%b want 80 e0", pc, empty); end
    drive(3'd0, 32'h0, 32'h0, 1'b1, 1'b1);
    tick();
    cmp++; if (pc !== 32'h84 || empty !== 1'b0) begin bad++; $display("FAIL push_pop got pc %h e%b want 84 e0", pc, empty); end
    drive(3'd4, 32'h0, 32'h0, 1'b0, 1'b1);
    tick();
    cmp++; if (pc !== 32'h84 || empty !== 1'b1) begin bad++; $display("FAIL replaced_top got pc %h e%b want 84 e1", pc, empty); end
  endtask

  task automatic test_wrap;
    drive(3'd2, 32'h0, 32'hFFFF_FFFC, 1'b0, 1'b0);
    tick();
    cmp++; if (pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL to_top got %h want fffffffc", pc); end
    tvec = 32'h1000;
    drive(3'd3, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    cmp++; if (pc !== 32'h1000) begin bad++; $display("FAIL trap got %h want 1000", pc); end
    drive(3'd2, 32'h0, 32'hFFFF_FFFC, 1'b0, 1'b0);
    tick();
    drive(3'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    cmp++; if (pc !== 32'h0 || mis !== 1'b0) begin bad++; $display("FAIL wrap got pc %h m%b want 0 m0", pc, mis); end
  endtask

  initial begin
    test_reset();
    test_rel_reg();
    test_misaligned();
    test_ras();
    test_stall();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
